round_key_addr_seq: RTL
=======================

# round_key_addr_seq

Parametrised round-key address sequencer for the AES LUT core. On a start request it generates the read addresses of the expanded key schedule in the key BRAM for AES-128/192/256. Words are produced in round order for encryption and in reverse round order for decryption. Each word is handed to the round datapath under a valid/advance handshake with stall support, and completion is signalled by a done pulse.

## Interface
Parameters:
- ADDR_W, 8, key BRAM address width
- KEY_BASE, 0, BRAM address of schedule word 0; KEY_BASE+59 must be < 2**ADDR_W (elaboration-time check)
- WPR, 4, 32-bit words per round key; fixed by AES, exposed for checking only

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = encrypt (ascending rounds), 1 = decrypt (descending rounds); latched at start
- key_len  in  2  0 = AES-128 (Nr=10), 1 = AES-192 (Nr=12), 2 = AES-256 (Nr=14), 3 = reserved; latched at start
- advance  in  1  consumer accepts current word; low = stall
- addr  out  ADDR_W  current key BRAM address
- valid  out  1  addr/round/word are meaningful
- round  out  4  round index in processing order, 0..Nr
- word  out  2  word index within round, 0..3
- last  out  1  current word is the final word of the schedule
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the last word is accepted
- err  out  1  one-cycle pulse when start is rejected (key_len = 3)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, key_len≠3: latch mode and Nr; clear round and word to 0; go to RUN.
- IDLE, start=1, key_len=3: pulse err; stay in IDLE.
- RUN: valid=1. Each cycle with advance=1, word increments. At word=3, word wraps to 0 and round increments.
- RUN, valid & advance & last: go to DONE.
- DONE: done=1 and valid=0 for one cycle, then go to IDLE.
- start outside IDLE is ignored; latched mode and key_len are unaffected.
- Address rule: encrypt gives KEY_BASE + 4·round + word; decrypt gives KEY_BASE + 4·(Nr − round) + word. Word order within a round is always ascending.
- Total words per schedule is 4·(Nr+1): 44, 52 or 60.
- last = (round == Nr) && (word == 3).
- The address is computed in ADDR_W+1 bits; overflow is excluded by the parameter check.

## Timing
- Reset: state=IDLE. addr, round, word, valid, last, busy, done and err all 0.
- Start accepted at edge T: busy=1 and valid=1 from T+1, with the first address presented at T+1. Latency is 1 cycle.
- With advance held high, one word per cycle: 44/52/60 words in 44/52/60 cycles. done is high in the cycle after the last accepted word.
- advance=0: addr, round, word and last hold unchanged. There is no limit on stall length.
- advance while valid=0 is ignored.
- err is high in the cycle after the rejected start.
- Reset asserted mid-RUN: the block returns immediately to IDLE with reset values. No done pulse is issued.
- All outputs are registered. There is no combinational path from advance to addr.

## Structure
- Package aes_key_pkg holds:
  - the key_len encoding constants
  - function nr_of(key_len), returning 10/12/14
  - WPR
  - the state typedef {IDLE, RUN, DONE}
- Sub-module round_word_counter: a 2-bit word counter plus 4-bit round counter with enable, wrap and terminal flag. The top level holds the FSM and the address mapping.

## Test plan
- Encrypt, key_len=0, KEY_BASE=0, advance held 1 -> addr 0..43 in 44 consecutive cycles; last high only at addr 43; done pulses once in the following cycle.
- Decrypt, key_len=2 -> addr sequence 56,57,58,59,52,…,0,1,2,3 with round counting 0..14; 60 words in total.
- Encrypt, key_len=1, KEY_BASE=60, advance toggled 1/0 -> addresses 60..111 each presented until accepted; no duplicate or skipped addresses; 52 words.
- key_len=3 with start -> err pulses 1 cycle; busy and valid stay 0. A start issued mid-RUN is ignored and the sequence is unaltered.
- rst asserted at word 20 of an AES-128 run -> all outputs 0 immediately. A fresh start afterwards restarts at KEY_BASE.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES round-key address sequencer: key-length
// encoding, round-count lookup and the sequencer state type.
package aes_key_pkg;

    localparam logic [1:0] KL_128  = 2'd0;
    localparam logic [1:0] KL_192  = 2'd1;
    localparam logic [1:0] KL_256  = 2'd2;
    localparam logic [1:0] KL_RSVD = 2'd3;

    localparam int WPR = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of rounds Nr; the reserved code never reaches this lookup in use.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/round_word_counter.sv
// Word-within-round (2 bit) and round (4 bit) counter with synchronous clear,
// increment enable and a registered terminal flag (round == nr, word == 3).
module round_word_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [3:0] nr,
    output logic [3:0] round,
    output logic [1:0] word,
    output logic       last,
    output logic [3:0] round_inc,
    output logic [1:0] word_inc
);

    logic [3:0] round_next;
    logic [1:0] word_next;

    // *_inc is the position after one advance, regardless of en, so the
    // parent can map the next address without depending on its own enables.
    always_comb begin
        word_inc   = word + 2'd1;
        round_inc  = (word == 2'd3) ? round + 4'd1 : round;
        round_next = round;
        word_next  = word;
        if (clear) begin
            round_next = 4'd0;
            word_next  = 2'd0;
        end else if (en) begin
            round_next = round_inc;
            word_next  = word_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round <= 4'd0;
            word  <= 2'd0;
            last  <= 1'b0;
        end else begin
            round <= round_next;
            word  <= word_next;
            last  <= (round_next == nr) && (word_next == 2'd3);
        end
    end

endmodule

// File: rtl/round_key_addr_seq.sv
// Round-key address sequencer: walks the expanded key schedule in the key BRAM
// in round order (encrypt) or reverse round order (decrypt) under valid/advance.
module round_key_addr_seq
    import aes_key_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int KEY_BASE = 0,
    parameter int WPR      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [1:0]        key_len,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [3:0]        round,
    output logic [1:0]        word,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    generate
        if (KEY_BASE < 0 || KEY_BASE + 59 >= 2**ADDR_W) begin : g_base_chk
            $error("round_key_addr_seq: KEY_BASE+59 does not fit in ADDR_W bits");
        end
        if (WPR != aes_key_pkg::WPR) begin : g_wpr_chk
            $error("round_key_addr_seq: WPR must be 4");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic              mode_reg, mode_next;
    logic [3:0]        nr_reg, nr_next;
    logic              cnt_clear, cnt_en;
    logic              err_next;
    logic [ADDR_W-1:0] addr_next;
    logic [3:0]        round_inc;
    logic [1:0]        word_inc;

    logic              map_mode;
    logic [3:0]        map_nr, map_round, map_rel;
    logic [1:0]        map_word;
    logic [ADDR_W:0]   addr_full;
    logic [ADDR_W-1:0] addr_mapped;

    round_word_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .en        (cnt_en),
        .nr        (nr_reg),
        .round     (round),
        .word      (word),
        .last      (last),
        .round_inc (round_inc),
        .word_inc  (word_inc)
    );

    // In IDLE the mapping previews the first word of a new request; in RUN it
    // previews the word after the current one.
    always_comb begin
        if (state_reg == RUN) begin
            map_mode  = mode_reg;
            map_nr    = nr_reg;
            map_round = round_inc;
            map_word  = word_inc;
        end else begin
            map_mode  = mode;
            map_nr    = nr_of(key_len);
            map_round = 4'd0;
            map_word  = 2'd0;
        end
        map_rel   = map_mode ? (map_nr - map_round) : map_round;
        addr_full = (ADDR_W+1)'(KEY_BASE) + (ADDR_W+1)'({map_rel, map_word});
        // Overflow cannot happen once the base check holds; saturate, never wrap.
        addr_mapped = addr_full[ADDR_W-1:0] | {ADDR_W{addr_full[ADDR_W]}};
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        nr_next    = nr_reg;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        err_next   = 1'b0;
        addr_next  = addr;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (key_len == KL_RSVD) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = RUN;
                        mode_next  = mode;
                        nr_next    = nr_of(key_len);
                        cnt_clear  = 1'b1;
                        addr_next  = addr_mapped;
                    end
                end
            end
            RUN: begin
                if (advance) begin
                    if (last) begin
                        state_next = DONE;
                        cnt_clear  = 1'b1;
                        addr_next  = '0;
                    end else begin
                        cnt_en    = 1'b1;
                        addr_next = addr_mapped;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Status outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg <= 1'b0;
            nr_reg   <= 4'd10;
            addr     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            nr_reg   <= nr_next;
            addr     <= addr_next;
            valid    <= (state_next == RUN);
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
            err      <= err_next;
        end
    end

endmodule
